uop_xnor_match: RTL and testbench

Parametrised serial pattern matcher built on bitwise XNOR equality. Captures a qualified serial bit stream into an N-bit window and compares it each valid cycle against a pattern under a per-bit care mask. Reports matches as single-cycle pulses and keeps a saturating match count. Sits after any serial source in lab designs, e.g. a UART receiver or a sync-word hunter, and supersedes hand-instantiated gate comparators.

---
 rtl/uop_xnor_match.sv | 131 +++++++++++++
 tb/tb_uop_xnor_match.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uop_xnor_match.sv
// Serial pattern matcher: shifts qualified bits into an N-bit window and compares
// it against a masked pattern with XNOR equality, pulsing match and counting hits.
module uop_xnor_match #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          din,
    input  logic          din_valid,
    input  logic [N-1:0]  pattern,
    input  logic [N-1:0]  mask,
    input  logic          overlap,
    output logic          match,
    output logic [CW-1:0] match_count,
    output logic          sat,
    output logic          armed
);

    localparam int FW = $clog2(N);
    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_FILL    = 2'd1;
    localparam logic [1:0]    S_HUNT    = 2'd2;
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    function automatic logic xnor_hit(input logic [N-1:0] w, input logic [N-1:0] p,
                                      input logic [N-1:0] m);
        return &(~(w ^ p) | ~m);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    logic [1:0]    r_state;
    logic [FW-1:0] r_fill_cnt;
    logic [N-1:0]  r_sr;
    logic          r_match;
    logic [CW-1:0] r_count;
    logic          r_sat;

    logic [1:0]    w_state_nxt;
    logic [FW-1:0] w_fill_nxt;
    logic [N-1:0]  w_word;
    logic          w_cap;
    logic          w_eval;
    logic          w_hit;

    // The evaluated word already includes the bit arriving this cycle.
    assign w_word = {r_sr[N-2:0], din};
    assign w_cap  = en & din_valid & ~clr & (r_state != S_IDLE);
    assign w_eval = w_cap & ((r_state == S_HUNT) ||
                             ((r_state == S_FILL) && (r_fill_cnt == FILL_LAST)));
    assign w_hit  = w_eval & xnor_hit(w_word, pattern, mask);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        if (clr) begin
            w_state_nxt = en ? S_FILL : S_IDLE;
            w_fill_nxt  = '0;
        end else if (!en) begin
            w_state_nxt = S_IDLE;
            w_fill_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
                S_FILL: begin
                    if (din_valid) begin
                        if (r_fill_cnt == FILL_LAST) begin
                            w_state_nxt = (w_hit && !overlap) ? S_FILL : S_HUNT;
                            w_fill_nxt  = '0;
                        end else begin
                            w_fill_nxt = r_fill_cnt + FW'(1);
                        end
                    end
                end
                S_HUNT: begin
                    // Non-overlapping mode discards the window and refills from scratch.
                    if (w_hit && !overlap) begin
                        w_state_nxt = S_FILL;
                        w_fill_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= '0;
            r_sr       <= '0;
            r_match    <= 1'b0;
            r_count    <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_match    <= w_hit;
            if (w_cap) begin
                r_sr <= w_word;
            end
            if (clr) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_hit) begin
                r_count <= sat_inc(r_count);
                if (sat_inc(r_count) == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign sat         = r_sat;
    assign armed       = (r_state == S_HUNT);

endmodule

// File: tb/tb_uop_xnor_match.sv
// Directed bench for uop_xnor_match: an N=4/CW=8 instance for matching behaviour and
// an N=4/CW=2 instance sharing the same inputs for saturation.
module tb_uop_xnor_match;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       din;
    logic       din_valid;
    logic [3:0] pattern;
    logic [3:0] mask;
    logic       overlap;

    logic       match_a;
    logic [7:0] count_a;
    logic       sat_a;
    logic       armed_a;
    logic       match_s;
    logic [1:0] count_s;
    logic       sat_s;
    logic       armed_s;

    int n_vec = 0;
    int n_err = 0;

    uop_xnor_match #(.N(4), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .pattern(pattern), .mask(mask), .overlap(overlap),
        .match(match_a), .match_count(count_a), .sat(sat_a), .armed(armed_a)
    );

    uop_xnor_match #(.N(4), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .pattern(pattern), .mask(mask), .overlap(overlap),
        .match(match_s), .match_count(count_s), .sat(sat_s), .armed(armed_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic d, input logic v);
        din       = d;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] bits4;
        logic [7:0] exp8;
        logic [3:0] sr_exp [4];

        rst = 1'b1; en = 1'b0; clr = 1'b0; din = 1'b0; din_valid = 1'b0;
        pattern = 4'b0000; mask = 4'b0000; overlap = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", 32'(match_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_sat",   32'(sat_a),   32'd0);
        chk("rst_armed", 32'(armed_a), 32'd0);

        // Basic match: 1,0,1,1 against 1011
        en = 1'b1; pattern = 4'b1011; mask = 4'b1111; overlap = 1'b1;
        tick(1'b0, 1'b0);
        chk("rst_hold_armed", 32'(armed_a), 32'd0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        chk("idle_to_fill_armed", 32'(armed_a), 32'd0);
        bits4 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick(bits4[3-i], 1'b1);
            chk("basic_match", 32'(match_a), (i == 3) ? 32'd1 : 32'd0);
            chk("basic_armed", 32'(armed_a), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("basic_count", 32'(count_a), 32'd1);
        tick(1'b0, 1'b0);
        chk("basic_pulse_width", 32'(match_a), 32'd0);

        // Overlapping matches on 1,0,1,0,1,0,1,0 against 1010
        pattern = 4'b1010; clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        chk("clr_count", 32'(count_a), 32'd0);
        chk("clr_armed", 32'(armed_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick((i % 2) == 0, 1'b1);
            chk("ovl1_match", 32'(match_a), (i == 3 || i == 5 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("ovl1_count", 32'(count_a), 32'd3);

        // Non-overlapping: window refills after each hit
        overlap = 1'b0; clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick((i % 2) == 0, 1'b1);
            chk("ovl0_match", 32'(match_a), (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("ovl0_count", 32'(count_a), 32'd2);
        chk("ovl0_armed", 32'(armed_a), 32'd0);

        // Don't-care bits with valid gaps; window holds 1010 from the previous run
        overlap = 1'b1; pattern = 4'b0110; mask = 4'b0110; clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        bits4 = 4'b1110;
        sr_exp[0] = 4'b0101; sr_exp[1] = 4'b1011; sr_exp[2] = 4'b0111; sr_exp[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick(bits4[3-i], 1'b1);
            chk("gap_match", 32'(match_a), (i == 3) ? 32'd1 : 32'd0);
            chk("gap_sr", 32'(u_dut.r_sr), 32'(sr_exp[i]));
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick(~bits4[3-i], 1'b0);
                    chk("gap_idle_match", 32'(match_a), 32'd0);
                    chk("gap_sr_hold", 32'(u_dut.r_sr), 32'(sr_exp[i]));
                end
            end
        end
        chk("gap_count", 32'(count_a), 32'd1);

        // Saturation: mask=0 makes every evaluation a hit
        mask = 4'b0000; clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            chk("sat_fill_match", 32'(match_s), 32'd0);
        end
        for (int k = 1; k <= 6; k++) begin
            tick((k % 2) == 1, 1'b1);
            chk("sat_match", 32'(match_s), 32'd1);
            chk("sat_count", 32'(count_s), (k >= 3) ? 32'd3 : 32'(k));
            chk("sat_flag", 32'(sat_s), (k >= 3) ? 32'd1 : 32'd0);
            chk("wide_count", 32'(count_a), 32'(k));
            chk("wide_sat", 32'(sat_a), 32'd0);
        end
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        chk("sat_clr_count", 32'(count_s), 32'd0);
        chk("sat_clr_flag", 32'(sat_s), 32'd0);
        chk("wide_clr_count", 32'(count_a), 32'd0);

        // Async reset two bits into a refill, with a nonzero count beforehand
        pattern = 4'b1011; mask = 4'b1111; overlap = 1'b0;
        bits4 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick(bits4[3-i], 1'b1);
        end
        chk("pre_rst_match", 32'(match_a), 32'd1);
        chk("pre_rst_count", 32'(count_a), 32'd1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count_a), 32'd0);
        chk("async_rst_sat_count", 32'(count_s), 32'd0);
        chk("async_rst_sr", 32'(u_dut.r_sr), 32'd0);
        chk("async_rst_armed", 32'(armed_a), 32'd0);
        chk("async_rst_match", 32'(match_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0, 1'b0);
        chk("post_rst_armed", 32'(armed_a), 32'd0);

        // clr on the completing bit of a matching window
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        clr = 1'b1;
        tick(1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_win_match", 32'(match_a), 32'd0);
        chk("clr_win_count", 32'(count_a), 32'd0);
        chk("clr_win_armed", 32'(armed_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(bits4[3-i], 1'b1);
            chk("refill_match", 32'(match_a), (i == 3) ? 32'd1 : 32'd0);
        end
        exp8 = 8'd1;
        chk("refill_count", 32'(count_a), 32'(exp8));

        // en low forces IDLE and blocks evaluation
        overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(bits4[3-i], 1'b1);
        end
        chk("hunt_armed", 32'(armed_a), 32'd1);
        en = 1'b0;
        tick(1'b1, 1'b1);
        chk("en_low_armed", 32'(armed_a), 32'd0);
        chk("en_low_match", 32'(match_a), 32'd0);
        chk("en_low_count", 32'(count_a), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
